join_n: RTL
===========

Name: join_n

Overview:
- Clocked, parametrised N-way join for four-phase bundled-data channels; generalises the two-input C-element combine.
- Waits until every enabled input channel has raised its request, then issues one output request carrying the concatenated data.
- Fans the output acknowledge back to the participating inputs.
- Sits between self-timed producer stages and a single consumer inside the clocked islands of the async library.

Parameters:
N, 2, number of input channels (≥1)
W, 8, data width per channel

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset (rst=0 ⇒ reset)
r_i  input  N  per-channel request
a_i  output  N  per-channel acknowledge
d_i  input  N*W  per-channel data; channel k at bits [k*W +: W]
en_i  input  N  channel participation mask
r_o  output  1  output request
a_o  input  1  output acknowledge
d_o  output  N*W  captured data; disabled channels read 0
err  output  1  sticky protocol-violation flag

Behaviour:
- Reset values: r_o=0, a_i=0, d_o=0, err=0, state=IDLE. Arrived/departed vectors and latched mask are cleared.
- Reset mid-transaction aborts immediately, with no handshake completion.
- All outputs are registered.
- IDLE:
  - arrived[k] <= arrived[k] | (r_i[k] & en_i[k]).
  - en_i is sampled only in IDLE.
  - When (arrived | (r_i & en_i)) covers all of en_i and en_i≠0: latch mask, capture d_i (masked) into d_o, go to REQ.
  - r_o=1 appears the next cycle, i.e. 1 clk after the last request is seen.
  - en_i=0: stay in IDLE indefinitely; no empty join.
- REQ:
  - r_o=1. On a_o=1: a_i <= mask, go to ACK.
  - d_o is held stable from the REQ entry edge until IDLE re-entry.
- ACK:
  - departed[k] <= departed[k] | ~r_i[k], for masked channels only.
  - When every masked channel has departed: r_o <= 0, go to RTZ.
- RTZ: on a_o=0, a_i <= 0, clear arrived/departed, go to IDLE.
- Minimum cycle: 4 clk per transaction when the environment responds in 0 cycles.
- Simultaneous events:
  - Last request arriving together with an a_o glitch in IDLE: the join proceeds, and err is set (see violations below).
  - r_i re-rising in RTZ for a channel whose a_i is still 1: ignored until IDLE; it is then re-sampled as a new arrival.
- err is set (sticky until reset) on any of:
  - r_i[k] falling while arrived[k]=1 in IDLE;
  - a_o=1 in IDLE;
  - a_o falling in REQ or ACK;
  - r_i[k] rising for a masked channel in ACK after departed[k]=1.
- Normal operation continues after err is set.
- Unmasked channels: a_i stays 0; their r_i is ignored except in IDLE arrival tracking, which is gated by en_i.

Optional Feature:
- Macro: JOIN_N_SYNC_EN.
- Defined:
  - r_i (per bit) and a_o pass through two-flop synchronisers, so asynchronous neighbours are safe.
  - All latencies above grow by 2 clk.
  - d_i is captured from a 2-stage delayed copy aligned with the synchronised request.
  - Reset clears the synchronisers to 0.
- Undefined: r_i and a_o are used directly and are assumed synchronous to clk.

Decomposition:
- Package join_pkg holds:
  - state typedef enum {IDLE, REQ, ACK, RTZ}, 2 bits;
  - localparam for the synchroniser depth (2).
- Sub-module sync2: a two-flop synchroniser of parametrised width, instantiated only under JOIN_N_SYNC_EN.
- Everything else stays inside join_n: FSM, arrived/departed tracking, data capture, err logic.

Test Plan:
- Basic N=2, W=8, en_i=2'b11:
  - Stimulus: r_i[0]=1 at cycle 0, r_i[1]=1 at cycle 3, d_i=16'hB4A5.
  - Response: r_o=1 at cycle 4, d_o=16'hB4A5.
  - a_o=1 ⇒ a_i=2'b11 next cycle.
  - Both r_i drop ⇒ r_o=0; a_o=0 ⇒ a_i=0.
- Mask, N=4, en_i=4'b0101:
  - Stimulus: requests on channels 0 and 2 only, d_i=32'h44332211.
  - Response: r_o rises, d_o=32'h00330011, a_i=4'b0101.
  - Toggling r_i[1] has no effect.
- Empty mask: en_i=0 with all r_i=1 for 20 cycles ⇒ r_o stays 0, err=0.
- Violations (err stays 1 until rst=0, then 0):
  - r_i[0] 1→0 in IDLE before r_i[1] rises ⇒ err=1.
  - a_o=1 in IDLE ⇒ err=1.
- Reset mid-ACK:
  - Stimulus: rst=0 asynchronously while a_i=2'b11.
  - Response: a_i, r_o, d_o clear immediately; after release, a new transaction completes normally.
- JOIN_N_SYNC_EN build:
  - Stimulus: the basic scenario.
  - Response: r_o rises at cycle 6; full handshake completes with 2-clk extra latency on each phase.

Source files
------------

// File: rtl/join_pkg.sv
// join_pkg: shared state encoding and synchroniser depth for join_n.
package join_pkg;
  typedef enum logic [1:0] {IDLE, REQ, ACK, RTZ} state_t;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser of parametrised width, cleared by reset.
module sync2
  import join_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [SYNC_DEPTH-1:0][W-1:0] r_s;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_s <= '0;
    else      r_s <= {r_s[SYNC_DEPTH-2:0], i_d};
  assign o_q = r_s[SYNC_DEPTH-1];
endmodule

// File: rtl/join_n.sv
// join_n: clocked N-way join of four-phase bundled-data channels.
// Define JOIN_N_SYNC_EN to synchronise r_i/a_o (and delay d_i to match) for async neighbours.
module join_n
  import join_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   r_i,
  output logic [N-1:0]   a_i,
  input  logic [N*W-1:0] d_i,
  input  logic [N-1:0]   en_i,
  output logic           r_o,
  input  logic           a_o,
  output logic [N*W-1:0] d_o,
  output logic           err
);
  state_t         r_state, w_state;
  logic [N-1:0]   r_arr, r_dep, r_mask, r_ai;
  logic [N-1:0]   w_arr, w_dep, w_mask, w_ai, w_rq, w_cov;
  logic [N*W-1:0] r_do, w_do, w_d, w_dmask;
  logic           r_ro, w_ro, r_err, w_err, r_ao, w_ao;
`ifdef JOIN_N_SYNC_EN
  sync2 #(.W(N))   u_sync_r (.clk(clk), .rst(rst), .i_d(r_i), .o_q(w_rq));
  sync2 #(.W(1))   u_sync_a (.clk(clk), .rst(rst), .i_d(a_o), .o_q(w_ao));
  sync2 #(.W(N*W)) u_sync_d (.clk(clk), .rst(rst), .i_d(d_i), .o_q(w_d));
`else
  assign w_rq = r_i;
  assign w_ao = a_o;
  assign w_d  = d_i;
`endif
  always_comb begin
    w_state = r_state;
    w_arr   = r_arr;
    w_dep   = r_dep;
    w_mask  = r_mask;
    w_ai    = r_ai;
    w_do    = r_do;
    w_ro    = r_ro;
    w_err   = r_err;
    w_dmask = '0;
    for (int k = 0; k < N; k++) w_dmask[k*W +: W] = en_i[k] ? w_d[k*W +: W] : '0;
    w_cov = r_arr | (w_rq & en_i);
    case (r_state)
      IDLE: begin
        // arrived bits only ever set for enabled channels, so a drop here is a retracted request
        w_arr = w_cov;
        w_err = r_err | w_ao | (|(r_arr & ~w_rq));
        if (en_i != '0 && (w_cov & en_i) == en_i) begin
          w_mask  = en_i;
          w_do    = w_dmask;
          w_ro    = 1'b1;
          w_state = REQ;
        end
      end
      REQ: begin
        w_err = r_err | (r_ao & ~w_ao);
        if (w_ao) begin
          w_ai    = r_mask;
          w_state = ACK;
        end
      end
      ACK: begin
        w_dep = r_dep | (~w_rq & r_mask);
        w_err = r_err | (r_ao & ~w_ao) | (|(r_dep & w_rq & r_mask));
        if ((w_dep & r_mask) == r_mask) begin
          w_ro    = 1'b0;
          w_state = RTZ;
        end
      end
      RTZ: begin
        if (!w_ao) begin
          w_ai    = '0;
          w_arr   = '0;
          w_dep   = '0;
          w_state = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_arr   <= '0;
      r_dep   <= '0;
      r_mask  <= '0;
      r_ai    <= '0;
      r_do    <= '0;
      r_ro    <= 1'b0;
      r_err   <= 1'b0;
      r_ao    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_arr   <= w_arr;
      r_dep   <= w_dep;
      r_mask  <= w_mask;
      r_ai    <= w_ai;
      r_do    <= w_do;
      r_ro    <= w_ro;
      r_err   <= w_err;
      r_ao    <= w_ao;
    end
  end
  assign a_i = r_ai;
  assign r_o = r_ro;
  assign d_o = r_do;
  assign err = r_err;
endmodule
